// File: rtl/uart_pkg.sv
// uart_pkg: shared flow-control constants, arbiter state encoding and one-hot helper
package uart_pkg;
  localparam logic [7:0] XOFF = 8'h13;
  localparam logic [7:0] XON = 8'h11;
  typedef enum logic [1:0] {IDLE, ISSUE, SETTLE, DRAIN} state_t;
  function automatic logic [2:0] oh2idx(input logic [7:0] oh);
    oh2idx = '0;
    for (int i = 0; i < 8; i++) if (oh[i]) oh2idx = 3'(i);
  endfunction
endpackage

// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if: requester, uart_tx and uart_rx signals seen by the arbiter
interface uart_tx_arbiter_if #(parameter int NUM_REQ = 4);
  logic [NUM_REQ-1:0] req_valid_i;
  logic [8*NUM_REQ-1:0] req_data_i;
  logic [NUM_REQ-1:0] req_last_i;
  logic [NUM_REQ-1:0] req_ready_o;
  logic tx_write_o;
  logic [7:0] tx_data_o;
  logic tx_busy_i;
  logic rx_valid_i;
  logic [7:0] rx_data_i;
  modport slave (
    input req_valid_i, req_data_i, req_last_i, tx_busy_i, rx_valid_i, rx_data_i,
    output req_ready_o, tx_write_o, tx_data_o
  );
  modport master (
    output req_valid_i, req_data_i, req_last_i, tx_busy_i, rx_valid_i, rx_data_i,
    input req_ready_o, tx_write_o, tx_data_o
  );
endinterface

// File: rtl/uart_tx_arbiter_rr_pick.sv
// rr_pick: one-hot select of the first request at or above the pointer, wrapping
module rr_pick #(
  parameter int N = 4,
  parameter int PW = $clog2(N)
) (
  input logic [N-1:0] i_req,
  input logic [PW-1:0] i_ptr,
  output logic [N-1:0] o_gnt
);
  // scan offsets downward so the nearest request above the pointer wins last
  always_comb begin
    o_gnt = '0;
    for (int j = N - 1; j >= 0; j--)
      if (i_req[(int'(i_ptr) + j) % N]) o_gnt = {{(N-1){1'b0}}, 1'b1} << ((int'(i_ptr) + j) % N);
  end
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: packet-level round-robin sharing of one uart_tx with XON/XOFF pause
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter logic [7:0] XOFF_BYTE = XOFF,
  parameter logic [7:0] XON_BYTE = XON,
  parameter int LOCK_TIMEOUT = 65535
) (
  input logic clock,
  input logic reset_n,
  uart_tx_arbiter_if.slave bus,
  output logic [NUM_REQ-1:0] grant_o,
  output logic paused_o
);
  localparam int PW = $clog2(NUM_REQ);
  state_t r_state, w_state;
  logic [NUM_REQ-1:0] r_grant, w_grant, w_pick, r_ready;
  logic [PW-1:0] r_ptr, w_ptr, w_k, w_kp1;
  logic r_paused, r_write, w_issue, w_wait, w_tout, w_rel;
  logic [7:0] r_data;
  logic [15:0] r_cnt;
  rr_pick #(.N(NUM_REQ), .PW(PW)) u_pick (.i_req(bus.req_valid_i), .i_ptr(r_ptr), .o_gnt(w_pick));
  assign w_k = PW'(oh2idx(8'(r_grant)));
  assign w_kp1 = (w_k == PW'(NUM_REQ - 1)) ? '0 : w_k + PW'(1);
  assign w_issue = r_state == ISSUE && |r_grant && !r_paused && !bus.tx_busy_i && bus.req_valid_i[w_k];
  assign w_wait = r_state == ISSUE && |r_grant && !r_paused && !bus.req_valid_i[w_k];
  assign w_tout = w_wait && r_cnt == 16'(LOCK_TIMEOUT - 1);
  assign w_rel = (w_issue && bus.req_last_i[w_k]) || w_tout;
  // next state, grant and pointer: grant is held until the packet's last byte or a lock timeout
  always_comb begin
    w_state = r_state;
    w_grant = r_grant;
    w_ptr = r_ptr;
    case (r_state)
      IDLE: begin
        w_grant = |r_grant ? r_grant : w_pick;
        w_state = |w_grant ? ISSUE : IDLE;
      end
      ISSUE: begin
        w_grant = w_rel ? '0 : r_grant;
        w_ptr = w_rel ? w_kp1 : r_ptr;
        w_state = w_issue ? SETTLE : w_tout ? IDLE : ISSUE;
      end
      SETTLE: w_state = DRAIN;
      DRAIN: w_state = bus.tx_busy_i ? DRAIN : |r_grant ? ISSUE : IDLE;
      default: w_state = IDLE;
    endcase
  end
  // registered state, uart_tx write pulse, held data byte, pause flag and lock counter
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      r_state <= IDLE;
      r_grant <= '0;
      r_ptr <= '0;
      r_paused <= 1'b0;
      r_write <= 1'b0;
      r_ready <= '0;
      r_data <= '0;
      r_cnt <= '0;
    end else begin
      r_state <= w_state;
      r_grant <= w_grant;
      r_ptr <= w_ptr;
      r_paused <= bus.rx_valid_i && bus.rx_data_i == XOFF_BYTE ? 1'b1 :
                  bus.rx_valid_i && bus.rx_data_i == XON_BYTE ? 1'b0 : r_paused;
      r_write <= w_issue;
      r_ready <= w_issue ? r_grant : '0;
      r_data <= w_issue ? bus.req_data_i[{w_k, 3'b000} +: 8] : r_data;
      r_cnt <= w_wait && !w_tout ? r_cnt + 16'd1 : (r_state == ISSUE && r_paused) ? r_cnt : '0;
    end
  assign grant_o = r_grant;
  assign paused_o = r_paused;
  assign bus.tx_write_o = r_write;
  assign bus.tx_data_o = r_data;
  assign bus.req_ready_o = r_ready;
endmodule
